// File: rtl/decodeshift_pkg.sv
// rtl/decodeshift_pkg.sv - shared segment patterns, FSM states and widths for decodeshift
package decodeshift_pkg;

  localparam int SEG_BITS = 8;

  // Active-high {dp,g,f,e,d,c,b,a}; dp is never lit.
  localparam logic [SEG_BITS-1:0] SEG_0 = 8'h3F;
  localparam logic [SEG_BITS-1:0] SEG_1 = 8'h06;
  localparam logic [SEG_BITS-1:0] SEG_2 = 8'h5B;
  localparam logic [SEG_BITS-1:0] SEG_3 = 8'h4F;
  localparam logic [SEG_BITS-1:0] SEG_4 = 8'h66;
  localparam logic [SEG_BITS-1:0] SEG_5 = 8'h6D;
  localparam logic [SEG_BITS-1:0] SEG_6 = 8'h7D;
  localparam logic [SEG_BITS-1:0] SEG_7 = 8'h07;
  localparam logic [SEG_BITS-1:0] SEG_8 = 8'h7F;
  localparam logic [SEG_BITS-1:0] SEG_9 = 8'h6F;
  localparam logic [SEG_BITS-1:0] SEG_A = 8'h77;
  localparam logic [SEG_BITS-1:0] SEG_B = 8'h7C;
  localparam logic [SEG_BITS-1:0] SEG_C = 8'h39;
  localparam logic [SEG_BITS-1:0] SEG_D = 8'h5E;
  localparam logic [SEG_BITS-1:0] SEG_E = 8'h79;
  localparam logic [SEG_BITS-1:0] SEG_F = 8'h71;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    CLK
  } state_t;

  function automatic logic [SEG_BITS-1:0] seg_pattern(input logic [3:0] nibble);
    logic [SEG_BITS-1:0] p;
    case (nibble)
      4'h0: p = SEG_0;
      4'h1: p = SEG_1;
      4'h2: p = SEG_2;
      4'h3: p = SEG_3;
      4'h4: p = SEG_4;
      4'h5: p = SEG_5;
      4'h6: p = SEG_6;
      4'h7: p = SEG_7;
      4'h8: p = SEG_8;
      4'h9: p = SEG_9;
      4'hA: p = SEG_A;
      4'hB: p = SEG_B;
      4'hC: p = SEG_C;
      4'hD: p = SEG_D;
      4'hE: p = SEG_E;
      default: p = SEG_F;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/decodeshift_decoder.sv
// rtl/decodeshift_decoder.sv - combinational hex nibble to 7-segment pattern
module decodeshift_decoder
  import decodeshift_pkg::*;
(
  input  logic [3:0]          nibble,
  output logic [SEG_BITS-1:0] pattern
);

  assign pattern = seg_pattern(nibble);

endmodule

// File: rtl/decodeshift.sv
// rtl/decodeshift.sv - snapshots a counter, decodes digits and shifts patterns out in parallel
module decodeshift
  import decodeshift_pkg::*;
#(
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   cnt_in,
  input  logic                  trigger,
  output logic [DIGITS-1:0]     segOut,
  output logic                  shiftOut
);

  state_t                state, state_nxt;
  logic [2:0]            idx, idx_nxt;
  logic [4*DIGITS-1:0]   cnt_q, cnt_nxt;
  logic [4*DIGITS-1:0]   dec_in;
  logic                  trig_q;
  logic [DIGITS-1:0]     seg_nxt;
  logic                  shift_nxt;
  logic [SEG_BITS-1:0]   pattern [DIGITS];

  // While idle the decoders look at the live value so the first bit is ready on the start edge.
  assign dec_in = (state == IDLE) ? cnt_in : cnt_q;

  for (genvar i = 0; i < DIGITS; i++) begin : g_dec
    decodeshift_decoder u_dec (
      .nibble  (dec_in[4*i +: 4]),
      .pattern (pattern[i])
    );
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt_q;
    seg_nxt   = segOut;
    shift_nxt = shiftOut;
    case (state)
      IDLE: begin
        if (trigger && !trig_q) begin
          cnt_nxt   = cnt_in;
          idx_nxt   = 3'd7;
          shift_nxt = 1'b0;
          for (int i = 0; i < DIGITS; i++) seg_nxt[i] = pattern[i][SEG_BITS-1];
          state_nxt = DATA;
        end
      end
      DATA: begin
        shift_nxt = 1'b1;
        state_nxt = CLK;
      end
      CLK: begin
        shift_nxt = 1'b0;
        if (idx != 3'd0) begin
          idx_nxt = idx - 3'd1;
          for (int i = 0; i < DIGITS; i++) seg_nxt[i] = pattern[i][idx_nxt];
          state_nxt = DATA;
        end else begin
          seg_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      default: begin
        seg_nxt   = '0;
        shift_nxt = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= 3'd7;
      cnt_q    <= '0;
      trig_q   <= 1'b0;
      segOut   <= '0;
      shiftOut <= 1'b0;
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      cnt_q    <= cnt_nxt;
      trig_q   <= trigger;
      segOut   <= seg_nxt;
      shiftOut <= shift_nxt;
    end
  end

endmodule

// File: tb/tb_decodeshift.sv
// tb/tb_decodeshift.sv - randomized self-checking bench for decodeshift
module tb_decodeshift;

  localparam int DIGITS = 6;

  logic                clk = 1'b0;
  logic                reset;
  logic [4*DIGITS-1:0] cnt_in;
  logic                trigger;
  logic [DIGITS-1:0]   segOut;
  logic                shiftOut;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]          pat [16];
  int                  busy;
  logic                ptrig;
  logic [4*DIGITS-1:0] snap;
  logic [DIGITS-1:0]   exp_seg;
  logic                exp_sh;
  logic                prev_sh;
  int                  npulse;
  logic [DIGITS-1:0]   pulse_seg [8];

  decodeshift #(.DIGITS(DIGITS)) dut (
    .clk      (clk),
    .reset    (reset),
    .cnt_in   (cnt_in),
    .trigger  (trigger),
    .segOut   (segOut),
    .shiftOut (shiftOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  // Reference: a start opens a 16-clock window; clock e of it shows bit 7-e/2, shift high on odd e.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      busy  = 0;
      ptrig = 1'b0;
    end else begin
      if (busy == 0) begin
        if (trigger && !ptrig) begin
          snap = cnt_in;
          busy = 16;
        end
      end else begin
        busy = busy - 1;
      end
      ptrig = trigger;
    end
  end

  always @(negedge clk) begin
    int el, bp;
    if (busy == 0) begin
      exp_seg = '0;
      exp_sh  = 1'b0;
    end else begin
      el     = 16 - busy;
      bp     = 7 - el / 2;
      exp_sh = (el % 2) == 1;
      for (int i = 0; i < DIGITS; i++) exp_seg[i] = pat[snap[4*i +: 4]][bp];
    end
    check("segOut", 32'(segOut), 32'(exp_seg));
    check("shiftOut", 32'(shiftOut), 32'(exp_sh));
    if (shiftOut && !prev_sh) begin
      if (npulse < 8) pulse_seg[npulse] = segOut;
      npulse++;
    end
    prev_sh = shiftOut;
  end

  initial begin
    logic [7:0] s0, s5;
    int hi;
    pat = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
            8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
    busy    = 0;
    ptrig   = 1'b0;
    snap    = '0;
    prev_sh = 1'b0;
    npulse  = 0;
    reset   = 1'b1;
    trigger = 1'b0;
    cnt_in  = 24'h654321;
    repeat (10) step();
    check("reset_pulses", npulse, 0);

    reset   = 1'b0;
    npulse  = 0;
    trigger = 1'b1;
    repeat (5) step();
    trigger = 1'b0;
    repeat (5) step();
    cnt_in = 24'h123456;
    repeat (20) step();
    check("c1_pulses", npulse, 8);
    check("c1_dp", 32'(pulse_seg[0]), 32'h00);
    check("c1_g", 32'(pulse_seg[1]), 32'(6'b111110));
    check("c1_a", 32'(pulse_seg[7]), 32'(6'b110110));

    repeat (15) step();
    npulse  = 0;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    repeat (20) step();
    check("c2_pulses", npulse, 8);
    for (int k = 0; k < 8; k++) begin
      s0[7-k] = pulse_seg[k][0];
      s5[7-k] = pulse_seg[k][5];
    end
    check("c2_digit0_stream", 32'(s0), 32'h7D);
    check("c2_digit5_stream", 32'(s5), 32'h06);

    npulse  = 0;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    repeat (5) step();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    repeat (14) step();
    check("busy_pulses", npulse, 8);

    npulse  = 0;
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    hi = 0;
    for (int k = 0; k < 40 && hi < 4; k++) begin
      step();
      if (shiftOut) hi++;
    end
    check("rst_wait_pulse4", hi, 4);
    reset = 1'b1;
    #1;
    check("rst_async_seg", 32'(segOut), 32'h0);
    check("rst_async_shift", 32'(shiftOut), 32'h0);
    repeat (3) step();
    reset  = 1'b0;
    npulse = 0;
    repeat (25) step();
    check("post_rst_pulses", npulse, 0);

    for (int it = 0; it < 500; it++) begin
      cnt_in  = 24'($urandom);
      trigger = ($urandom_range(0, 3) == 0);
      reset   = ($urandom_range(0, 99) == 0);
      step();
    end
    reset   = 1'b0;
    trigger = 1'b0;
    repeat (20) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
